// File: rtl/ir_prefetch_queue_pkg.sv
// Processor-wide constants for the instruction prefetch path: default bus and
// instruction widths, opcode field width and the decoder's opcode encoding.
package ir_prefetch_queue_pkg;

    localparam int unsigned BusW    = 16;
    localparam int unsigned InstrW  = 8;
    localparam int unsigned OpcodeW = 4;

    // Opcode encoding shared with the control unit's decoder.
    typedef enum logic [OpcodeW-1:0] {
        OpNop   = 4'h0,
        OpLoad  = 4'h1,
        OpStore = 4'h2,
        OpAdd   = 4'h3,
        OpSub   = 4'h4,
        OpShr   = 4'h5,
        OpJmp   = 4'h6,
        OpJz    = 4'h7,
        OpIncA  = 4'h8,
        OpIncB  = 4'h9,
        OpHalt  = 4'hF
    } opcode_e;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int unsigned cnt_width(int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ir_prefetch_queue_if.sv
// Bus-side and decoder-side signals of the instruction prefetch queue.
// master: the fetch/decode side driving the queue; slave: the queue itself.
interface ir_prefetch_queue_if
    import ir_prefetch_queue_pkg::*;
#(
    parameter int unsigned BUS_W    = BusW,
    parameter int unsigned INSTR_W  = InstrW,
    parameter int unsigned OPCODE_W = OpcodeW,
    parameter int unsigned DEPTH    = 4
) ();

    logic [BUS_W-1:0]             in_bus;
    logic                         write;
    logic                         decode;
    logic                         flush;
    logic [INSTR_W-1:0]           out_bus;
    logic [OPCODE_W-1:0]          opcode;
    logic [INSTR_W-OPCODE_W-1:0]  operand;
    logic                         valid;
    logic                         full;
    logic [$clog2(DEPTH):0]       count;
    logic                         overflow;

    modport master (
        output in_bus, write, decode, flush,
        input  out_bus, opcode, operand, valid, full, count, overflow
    );

    modport slave (
        input  in_bus, write, decode, flush,
        output out_bus, opcode, operand, valid, full, count, overflow
    );

endinterface

// File: rtl/ir_fifo_mem.sv
// Circular instruction buffer: storage array plus read/write pointers that
// wrap modulo DEPTH. Flush resets both pointers and wins over push/pop.
module ir_fifo_mem
    import ir_prefetch_queue_pkg::*;
#(
    parameter int unsigned INSTR_W = InstrW,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] wdata_i,
    output logic [INSTR_W-1:0] rdata_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;

    // Pointer registers; natural binary wrap gives the modulo-DEPTH behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
    end

    // Storage write at the write pointer; cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction prefetch queue: buffers instruction words from the shared bus
// so fetch can run ahead of decode. Holds occupancy, flags, field split and
// the optional same-cycle bypass enabled by the IR_BYPASS_EN macro.
module ir_prefetch_queue
    import ir_prefetch_queue_pkg::*;
#(
    parameter int unsigned BUS_W    = BusW,
    parameter int unsigned INSTR_W  = InstrW,
    parameter int unsigned OPCODE_W = OpcodeW,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    ir_prefetch_queue_if.slave  bus
);

    localparam int unsigned CntW = cnt_width(DEPTH);

    logic [CntW-1:0]    count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [INSTR_W-1:0] head;
    logic [INSTR_W-1:0] out_word;
    logic               out_valid;
    logic               empty, full, push, pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));

    ir_fifo_mem #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.flush),
        .wdata_i (bus.in_bus[INSTR_W-1:0]),
        .rdata_o (head)
    );

    // Push/pop qualification and the head word presented to the decoder.
    always_comb begin
        push      = bus.write && (!full || bus.decode);
        pop       = bus.decode && !empty;
        out_word  = empty ? '0 : head;
        out_valid = !empty;
`ifdef IR_BYPASS_EN
        // Empty queue: forward the bus word; if decoded now it is never stored.
        if (empty && bus.write && !bus.flush) begin
            out_word  = bus.in_bus[INSTR_W-1:0];
            out_valid = 1'b1;
            if (bus.decode) push = 1'b0;
        end
`endif
    end

    // Occupancy and sticky overflow next-state; flush clears both.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.flush) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
            if (bus.write && full && !bus.decode) overflow_d = 1'b1;
        end
    end

    // Occupancy and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    if (BUS_W > INSTR_W) begin : g_unused_bus
        logic unused_bus_hi;
        assign unused_bus_hi = ^bus.in_bus[BUS_W-1:INSTR_W];
    end

    assign bus.out_bus  = out_word;
    assign bus.opcode   = out_word[INSTR_W-1 -: OPCODE_W];
    assign bus.operand  = out_word[INSTR_W-OPCODE_W-1:0];
    assign bus.valid    = out_valid;
    assign bus.full     = full;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule
